// File: rtl/waterbear_pkg.sv
// Shared types and constants for the waterbear program loader and its benches.
// The optional checksum trailer is selected with LOADER_CHECKSUM_EN.
package waterbear_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_COUNT,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

    localparam logic [3:0] OP_LDR = 4'h0;
    localparam logic [3:0] OP_STR = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_ORR = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_IN  = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Packs an instruction word in the core's {reserved, opcode, numbit, operand} layout.
    function automatic logic [15:0] make_instr(input logic [3:0] opcode,
                                               input logic       numbit,
                                               input logic [5:0] operand);
        return {5'b0_0000, opcode, numbit, operand};
    endfunction

endpackage

// File: rtl/waterbear_byte_timer.sv
// Idle-cycle counter: counts enabled cycles without a clear and flags the LIMIT-th one.
// LIMIT of 0 disables expiry entirely.
module waterbear_byte_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned    CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear || !enable) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // count_reg holds the number of idle cycles already seen, so this is the LIMIT-th one.
    assign expire = (LIMIT != 0) && enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/waterbear_prog_loader.sv
// Boot loader: parses HDR/ADDR/CNT/words frames from the host and writes program memory,
// holding the core in reset until a frame completes. LOADER_CHECKSUM_EN adds a CSUM trailer.
module waterbear_prog_loader
    import waterbear_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE       = DEFAULT_HDR_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t     state_reg;
    logic [7:0] addr_reg;
    logic [7:0] cnt_reg;
    logic [7:0] word_reg;
    logic [7:0] hi_reg;

    logic xfer;
    logic in_frame;
    logic timer_expire;

    assign xfer     = in_valid & in_ready;
    assign in_frame = state_reg inside {ST_ADDR, ST_COUNT, ST_DATA_HI,
                                        ST_DATA_LO, ST_WRITE, ST_CSUM};

    waterbear_byte_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .srst   (rst),
        .clear  (xfer),
        .enable (in_frame),
        .expire (timer_expire)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;

    // Running sum of ADDR, CNT and data bytes; restarted by any byte seen outside a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (xfer) begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR:                 sum_reg <= '0;
                ST_ADDR, ST_COUNT, ST_DATA_HI, ST_DATA_LO:  sum_reg <= sum_reg + in_data;
                default:                                    sum_reg <= sum_reg;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            word_reg  <= '0;
            hi_reg    <= '0;
        end else begin
            mem_we   <= 1'b0;
            in_ready <= 1'b1;
            if (timer_expire) begin
                state_reg <= ST_ERROR;
                busy      <= 1'b0;
                err       <= 1'b1;
                cpu_rst   <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (xfer && in_data == HDR_BYTE) begin
                            state_reg <= ST_ADDR;
                            busy      <= 1'b1;
                            cpu_rst   <= 1'b1;
                            done      <= 1'b0;
                            err       <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        if (xfer) begin
                            addr_reg  <= in_data;
                            state_reg <= ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (xfer) begin
                            cnt_reg   <= in_data;
                            word_reg  <= '0;
                            state_reg <= ST_DATA_HI;
                        end
                    end
                    ST_DATA_HI: begin
                        if (xfer) begin
                            hi_reg    <= in_data;
                            state_reg <= ST_DATA_LO;
                        end
                    end
                    ST_DATA_LO: begin
                        // Outputs are registered, so the strobe lands in the WRITE cycle itself.
                        if (xfer) begin
                            mem_we    <= 1'b1;
                            in_ready  <= 1'b0;
                            mem_addr  <= addr_reg;
                            mem_wdata <= {hi_reg, in_data};
                            state_reg <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        addr_reg <= addr_reg + 8'd1;
                        if (word_reg == cnt_reg) begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg <= ST_CSUM;
`else
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_rst   <= 1'b0;
`endif
                        end else begin
                            word_reg  <= word_reg + 8'd1;
                            state_reg <= ST_DATA_HI;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (xfer) begin
                            busy <= 1'b0;
                            if (in_data == sum_reg) begin
                                state_reg <= ST_DONE;
                                done      <= 1'b1;
                                cpu_rst   <= 1'b0;
                            end else begin
                                state_reg <= ST_ERROR;
                                err       <= 1'b1;
                                cpu_rst   <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
